// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS-style EX-stage ALU: default datapath width and
// the 4-bit ALU control codes decoded by mips_alu.
package mips_alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [3:0] aluop_t;

    localparam aluop_t ALUOP_AND = 4'b0000;
    localparam aluop_t ALUOP_OR  = 4'b0001;
    localparam aluop_t ALUOP_ADD = 4'b0010;
    localparam aluop_t ALUOP_SUB = 4'b0110;
    localparam aluop_t ALUOP_SLT = 4'b0111;
    localparam aluop_t ALUOP_NOR = 4'b1100;

    // SLT and SUB both need the adder in subtract mode.
    function automatic logic uses_subtract(input aluop_t op);
        return (op == ALUOP_SUB) || (op == ALUOP_SLT);
    endfunction

endpackage

// File: rtl/mips_alu_addsub.sv
// Single shared adder/subtractor: sum = a + (b ^ {sub}) + sub, with carry-out
// and two's-complement signed-overflow detection.
module mips_alu_addsub
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = b ^ {WIDTH{sub}};
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Overflow iff the effective operands agree in sign and the sum disagrees.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS-style ALU with one cycle of latency: AND/OR/ADD/SUB/SLT/NOR.
// Define MIPS_ALU_OVERFLOW_EN to add the registered signed-overflow output.
module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             inClk,
    input  logic             inRst_n,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [3:0]       inALUop,
    output logic [WIDTH-1:0] outALUresult,
    output logic             outZero
`ifdef MIPS_ALU_OVERFLOW_EN
    ,
    output logic             outOverflow
`endif
);

    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             carry_unused;
    logic             sum_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] result_d;

    assign sub = uses_subtract(inALUop);

    mips_alu_addsub #(
        .WIDTH    (WIDTH)
    ) u_addsub (
        .a        (inA),
        .b        (inB),
        .sub      (sub),
        .sum      (sum),
        .carry    (carry_unused),
        .overflow (sum_ovf)
    );

    // The sign of A-B is wrong exactly when the subtraction overflowed.
    assign slt_bit = sum[WIDTH-1] ^ sum_ovf;

    always_comb begin
        // NOTE: default first so every path assigns result_d and no latch is inferred.
        result_d = '0;
        case (inALUop)
            ALUOP_AND: result_d = inA & inB;
            ALUOP_OR:  result_d = inA | inB;
            ALUOP_ADD: result_d = sum;
            ALUOP_SUB: result_d = sum;
            ALUOP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
            ALUOP_NOR: result_d = ~(inA | inB);
            default:   result_d = '0;
        endcase
    end

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            outALUresult <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            outALUresult <= result_d;
        end
    end

    // Decoded from the result register itself, so it can never lag the result.
    assign outZero = ~|outALUresult;

`ifdef MIPS_ALU_OVERFLOW_EN
    logic ovf_d;

    assign ovf_d = ((inALUop == ALUOP_ADD) || (inALUop == ALUOP_SUB)) && sum_ovf;

    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            outOverflow <= 1'b0;
        end else begin
            outOverflow <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vector table, reset/glitch
// sequences, then randomized ops checked against an arithmetic reference model.
module tb_mips_alu;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] result;
    logic         zero;
`ifdef MIPS_ALU_OVERFLOW_EN
    logic         ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_alu dut (
        .inClk        (clk),
        .inRst_n      (rst_n),
        .inA          (a),
        .inB          (b),
        .inALUop      (op),
        .outALUresult (result),
        .outZero      (zero)
`ifdef MIPS_ALU_OVERFLOW_EN
        ,
        .outOverflow  (ovf)
`endif
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each opcode.
    function automatic void model(input logic [3:0] m_op, input logic [W-1:0] m_a,
                                  input logic [W-1:0] m_b, output logic [W-1:0] m_res,
                                  output logic m_ovf);
        longint sa = longint'($signed(m_a));
        longint sb = longint'($signed(m_b));
        longint wide;
        m_res = '0;
        m_ovf = 1'b0;
        case (m_op)
            4'b0000: m_res = m_a & m_b;
            4'b0001: m_res = m_a | m_b;
            4'b0010: begin
                m_res = m_a + m_b;
                wide  = sa + sb;
                m_ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0110: begin
                m_res = m_a - m_b;
                wide  = sa - sb;
                m_ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'b0111: m_res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: m_res = ~(m_a | m_b);
            default: m_res = '0;
        endcase
    endfunction

    // Called at a falling edge: drive, let one rising edge register, compare at next falling edge.
    task automatic run_vec(input string name, input vec_t v);
        op = v.op;
        a  = v.a;
        b  = v.b;
        @(posedge clk);
        @(negedge clk);
        check({name, ".res"}, result, v.res);
        check({name, ".zero"}, {31'b0, zero}, {31'b0, v.zero});
`ifdef MIPS_ALU_OVERFLOW_EN
        check({name, ".ovf"}, {31'b0, ovf}, {31'b0, v.ovf});
`endif
    endtask

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        logic [W-1:0] mres;
        logic         movf;

        tbl[0]  = '{4'b0000, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[3]  = '{4'b1100, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
        tbl[4]  = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[5]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        tbl[6]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[7]  = '{4'b0010, 32'hD8A3B8D4, 32'h63B9D6F2, 32'h3C5D8FC6, 1'b0, 1'b0};
        tbl[8]  = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[9]  = '{4'b0110, 32'h00000001, 32'h80000001, 32'h80000000, 1'b0, 1'b1};
        tbl[10] = '{4'b0110, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[11] = '{4'b0111, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        tbl[12] = '{4'b0111, 32'h00000001, 32'h80000001, 32'h00000000, 1'b1, 1'b0};
        tbl[13] = '{4'b0111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[14] = '{4'b0111, 32'hD8A3B8D4, 32'h63B9D6F2, 32'h00000001, 1'b0, 1'b0};
        tbl[15] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tbl[16] = '{4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        op    = 4'b0001;
        a     = 32'hDEADBEEF;
        b     = 32'h00000000;
        #1;
        check("reset.res", result, 32'h0);
        check("reset.zero", {31'b0, zero}, 32'h1);
`ifdef MIPS_ALU_OVERFLOW_EN
        check("reset.ovf", {31'b0, ovf}, 32'h0);
`endif
        @(posedge clk);
        #1;
        check("reset_held.res", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Async reset mid-stream, held until the first edge after release
        op = 4'b0010; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #2;
        check("pre_rst.res", result, 32'd11);
        rst_n = 1'b0;
        #1;
        check("async_rst.res", result, 32'h0);
        check("async_rst.zero", {31'b0, zero}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_edge.res", result, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release.res", result, 32'h0);
        check("rst_release.zero", {31'b0, zero}, 32'h1);
        @(posedge clk);
        #1;
        check("post_rst.res", result, 32'd11);
        check("post_rst.zero", {31'b0, zero}, 32'h0);
        @(negedge clk);

        // Input glitches between edges must not matter
        op = 4'b0001; a = 32'hFFFF0000; b = 32'h0000FFFF;
        #2 op = 4'b0000;
        #1 a = 32'h00000F00; b = 32'h0000FF00;
        @(posedge clk);
        @(negedge clk);
        check("glitch.res", result, 32'h00000F00);

        // Randomized back-to-back operations
        for (int i = 0; i < 300; i++) begin
            int sel = $urandom_range(0, 9);
            case (sel)
                0, 1: v.op = 4'b0010;
                2, 3: v.op = 4'b0110;
                4, 5: v.op = 4'b0111;
                6:    v.op = 4'b0000;
                7:    v.op = 4'b0001;
                8:    v.op = 4'b1100;
                default: v.op = 4'($urandom_range(0, 15));
            endcase
            v.a = ($urandom_range(0, 4) == 0) ? {$urandom_range(0, 1) == 1, 31'h7FFFFFFF} : $urandom;
            v.b = ($urandom_range(0, 4) == 0) ? v.a : $urandom;
            model(v.op, v.a, v.b, mres, movf);
            v.res  = mres;
            v.zero = (mres == '0);
            v.ovf  = movf;
            run_vec($sformatf("rnd%0d_op%b", i, v.op), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
